dcache_refill_ctrl: RTL and testbench

//  Miss/refill sequencer between the MEM-stage data cache and the 128-bit block data memory.
//  - On a cache miss it freezes the pipeline.
//  - If the victim line is dirty, it writes that line back to memory.
//  - It then fetches the missing 16-byte block and loads it into the cache in a single fill pulse.
//  - It returns the cache to normal operation and keeps miss and write-back statistics.

---
 rtl/dcache_refill_ctrl.sv | 132 +++++++++++++
 tb/tb_dcache_refill_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_refill_ctrl.sv
// Miss/refill sequencer between the MEM-stage data cache and the 128-bit block memory:
// optional dirty-victim write-back, block fetch, single-cycle cache fill, saturating statistics.
module dcache_refill_ctrl #(
  parameter int unsigned MEM_LAT = 2,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_read,
  input  logic             cpu_write,
  input  logic [63:0]      cpu_addr,
  input  logic             miss,
  input  logic             victim_dirty,
  input  logic [63:0]      victim_addr,
  input  logic [127:0]     victim_block,
  input  logic [127:0]     mem_block_rdata,
  output logic [63:0]      mem_address,
  output logic [127:0]     mem_write_data,
  output logic             mem_read,
  output logic             mem_write,
  output logic             fill_en,
  output logic [63:0]      fill_addr,
  output logic [127:0]     fill_block,
  output logic             stall,
  output logic [1:0]       state_dbg,
  output logic [CNT_W-1:0] miss_count,
  output logic [CNT_W-1:0] wb_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    RD   = 2'd2,
    FILL = 2'd3
  } state_t;

  localparam logic [3:0] LAT_RELOAD = 4'(MEM_LAT - 1);

  state_t       state, state_nxt;
  logic [3:0]   lat_cnt, lat_nxt;
  logic [63:0]  line_addr;
  logic [63:0]  wb_addr;
  logic [127:0] wb_data;
  logic         req;
  logic         start;
  logic         capture;

  assign req       = (cpu_read | cpu_write) & miss;
  assign start     = (state == IDLE) && req;
  assign state_dbg = state;

  always_comb begin
    state_nxt      = state;
    lat_nxt        = lat_cnt;
    capture        = 1'b0;
    stall          = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    fill_en        = 1'b0;
    fill_addr      = '0;
    case (state)
      IDLE: begin
        // Combinational stall freezes the pipeline in the very cycle the miss appears.
        stall = req;
        if (req) begin
          lat_nxt   = LAT_RELOAD;
          state_nxt = victim_dirty ? WB : RD;
        end
      end
      WB: begin
        stall          = 1'b1;
        mem_write      = 1'b1;
        mem_address    = wb_addr;
        mem_write_data = wb_data;
        if (lat_cnt == 4'd0) begin
          lat_nxt   = LAT_RELOAD;
          state_nxt = RD;
        end else begin
          lat_nxt = lat_cnt - 4'd1;
        end
      end
      RD: begin
        stall       = 1'b1;
        mem_read    = 1'b1;
        mem_address = line_addr;
        if (lat_cnt == 4'd0) begin
          capture   = 1'b1;
          state_nxt = FILL;
        end else begin
          lat_nxt = lat_cnt - 4'd1;
        end
      end
      FILL: begin
        stall     = 1'b1;
        fill_en   = 1'b1;
        fill_addr = line_addr;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      lat_cnt    <= '0;
      line_addr  <= '0;
      wb_addr    <= '0;
      wb_data    <= '0;
      fill_block <= '0;
      miss_count <= '0;
      wb_count   <= '0;
    end else begin
      state   <= state_nxt;
      lat_cnt <= lat_nxt;
      if (start) begin
        line_addr <= cpu_addr & ~64'hF;
        wb_addr   <= victim_addr;
        wb_data   <= victim_block;
        if (miss_count != '1)
          miss_count <= miss_count + 1'b1;
        if (victim_dirty && (wb_count != '1))
          wb_count <= wb_count + 1'b1;
      end
      if (capture)
        fill_block <= mem_block_rdata;
    end
  end

endmodule

// File: tb/tb_dcache_refill_ctrl.sv
// Randomized bench for dcache_refill_ctrl: a transaction-level model predicts the per-cycle
// bus/stall trace of each miss and the saturating statistics for two parameterizations.
module tb_dcache_refill_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         cpu_read, cpu_write, victim_dirty;
  logic [63:0]  cpu_addr, victim_addr;
  logic [127:0] victim_block, mem_rdata;
  logic         miss_a, miss_b;

  logic [63:0]  a_mem_address, a_fill_addr, b_mem_address, b_fill_addr;
  logic [127:0] a_mem_write_data, a_fill_block, b_mem_write_data, b_fill_block;
  logic         a_mem_read, a_mem_write, a_fill_en, a_stall;
  logic         b_mem_read, b_mem_write, b_fill_en, b_stall;
  logic [1:0]   a_state, b_state;
  logic [31:0]  a_miss_count, a_wb_count;
  logic [1:0]   b_miss_count, b_wb_count;

  dcache_refill_ctrl #(.MEM_LAT(2), .CNT_W(32)) dut_a (
    .clk(clk), .reset(rst_n), .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
    .miss(miss_a), .victim_dirty(victim_dirty), .victim_addr(victim_addr),
    .victim_block(victim_block), .mem_block_rdata(mem_rdata),
    .mem_address(a_mem_address), .mem_write_data(a_mem_write_data), .mem_read(a_mem_read),
    .mem_write(a_mem_write), .fill_en(a_fill_en), .fill_addr(a_fill_addr),
    .fill_block(a_fill_block), .stall(a_stall), .state_dbg(a_state),
    .miss_count(a_miss_count), .wb_count(a_wb_count)
  );

  dcache_refill_ctrl #(.MEM_LAT(1), .CNT_W(2)) dut_b (
    .clk(clk), .reset(rst_n), .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
    .miss(miss_b), .victim_dirty(victim_dirty), .victim_addr(victim_addr),
    .victim_block(victim_block), .mem_block_rdata(mem_rdata),
    .mem_address(b_mem_address), .mem_write_data(b_mem_write_data), .mem_read(b_mem_read),
    .mem_write(b_mem_write), .fill_en(b_fill_en), .fill_addr(b_fill_addr),
    .fill_block(b_fill_block), .stall(b_stall), .state_dbg(b_state),
    .miss_count(b_miss_count), .wb_count(b_wb_count)
  );

  int           sel;
  logic [63:0]  o_addr, o_faddr, o_mc, o_wc;
  logic [127:0] o_wdata, o_fblock;
  logic         o_rd, o_wr, o_fe, o_stall;
  logic [1:0]   o_state;

  always_comb begin
    if (sel == 1) begin
      o_addr = b_mem_address; o_faddr = b_fill_addr; o_wdata = b_mem_write_data;
      o_fblock = b_fill_block; o_rd = b_mem_read; o_wr = b_mem_write; o_fe = b_fill_en;
      o_stall = b_stall; o_state = b_state;
      o_mc = 64'(b_miss_count); o_wc = 64'(b_wb_count);
    end else begin
      o_addr = a_mem_address; o_faddr = a_fill_addr; o_wdata = a_mem_write_data;
      o_fblock = a_fill_block; o_rd = a_mem_read; o_wr = a_mem_write; o_fe = a_fill_en;
      o_stall = a_stall; o_state = a_state;
      o_mc = 64'(a_miss_count); o_wc = 64'(a_wb_count);
    end
  end

  int errors = 0;
  int checks = 0;

  longint unsigned mc[2];
  longint unsigned wc[2];
  longint unsigned cmax[2] = '{64'hFFFF_FFFF, 64'd3};
  int unsigned     lat[2]  = '{2, 1};

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic longint unsigned sat_inc(input longint unsigned v, input longint unsigned m);
    return (v >= m) ? m : v + 1;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic expect_cycle(input string tag, input bit st, input bit rd, input bit wr,
                              input logic [63:0] a, input logic [127:0] wd, input bit fe,
                              input logic [63:0] fa, input logic [1:0] s);
    @(negedge clk);
    check({tag, ".stall"}, o_stall, st);
    check({tag, ".mem_read"}, o_rd, rd);
    check({tag, ".mem_write"}, o_wr, wr);
    check({tag, ".mem_address"}, o_addr, a);
    check({tag, ".mem_write_data"}, o_wdata, wd);
    check({tag, ".fill_en"}, o_fe, fe);
    check({tag, ".fill_addr"}, o_faddr, fa);
    check({tag, ".state"}, o_state, s);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_miss(input int s, input logic v);
    miss_a = (s == 0) ? v : 1'b0;
    miss_b = (s == 1) ? v : 1'b0;
  endtask

  // Inputs other than mem_rdata are don't-care once a refill is under way.
  task automatic scramble(input int s);
    cpu_read = 1'($urandom); cpu_write = 1'($urandom); cpu_addr = rnd64();
    victim_dirty = 1'($urandom); victim_addr = rnd64(); victim_block = rnd128();
    mem_rdata = rnd128();
    set_miss(s, 1'($urandom));
  endtask

  task automatic do_miss(input int s, input logic [63:0] addr, input bit isrd, input bit iswr,
                         input bit dirty, input logic [63:0] va, input logic [127:0] vb,
                         input logic [127:0] rdata);
    logic [63:0] line;
    line = addr & ~64'hF;
    sel = s;
    cpu_read = isrd; cpu_write = iswr; cpu_addr = addr; victim_dirty = dirty;
    victim_addr = va; victim_block = vb; mem_rdata = rnd128();
    set_miss(s, 1'b1);
    expect_cycle("idle_req", 1, 0, 0, '0, '0, 0, '0, 2'd0);
    mc[s] = sat_inc(mc[s], cmax[s]);
    if (dirty) wc[s] = sat_inc(wc[s], cmax[s]);
    next_cycle();
    if (dirty) begin
      for (int unsigned i = 0; i < lat[s]; i++) begin
        scramble(s);
        expect_cycle("wb", 1, 0, 1, va, vb, 0, '0, 2'd1);
        next_cycle();
      end
    end
    for (int unsigned i = 0; i < lat[s]; i++) begin
      scramble(s);
      if (i == lat[s] - 1) mem_rdata = rdata;
      expect_cycle("rd", 1, 1, 0, line, '0, 0, '0, 2'd2);
      next_cycle();
    end
    scramble(s);
    expect_cycle("fill", 1, 0, 0, '0, '0, 1, line, 2'd3);
    check("fill.fill_block", o_fblock, rdata);
    check("fill.miss_count", o_mc, mc[s]);
    check("fill.wb_count", o_wc, wc[s]);
    next_cycle();
    cpu_read = 1'b0; cpu_write = 1'b0;
    set_miss(s, 1'b0);
  endtask

  task automatic hits(input int s, input int n);
    sel = s;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 2) != 0) begin
        set_miss(s, 1'b0);
        cpu_read = 1'($urandom); cpu_write = 1'($urandom);
      end else begin
        set_miss(s, 1'b1);
        cpu_read = 1'b0; cpu_write = 1'b0;
      end
      cpu_addr = rnd64(); victim_dirty = 1'($urandom); victim_addr = rnd64();
      victim_block = rnd128(); mem_rdata = rnd128();
      expect_cycle("hit", 0, 0, 0, '0, '0, 0, '0, 2'd0);
      check("hit.miss_count", o_mc, mc[s]);
      check("hit.wb_count", o_wc, wc[s]);
      next_cycle();
    end
    cpu_read = 1'b0; cpu_write = 1'b0;
    set_miss(s, 1'b0);
  endtask

  task automatic rand_miss(input int s, input bit force_dirty);
    int unsigned kind;
    kind = $urandom_range(1, 3);
    do_miss(s, rnd64(), kind[0], kind[1], force_dirty | 1'($urandom),
            rnd64() & ~64'hF, rnd128(), rnd128());
  endtask

  initial begin
    sel = 0;
    mc = '{0, 0}; wc = '{0, 0};
    rst_n = 1'b0;
    cpu_read = 1'b0; cpu_write = 1'b0; cpu_addr = '0; victim_dirty = 1'b0;
    victim_addr = '0; victim_block = '0; mem_rdata = '0; miss_a = 1'b0; miss_b = 1'b0;

    expect_cycle("reset", 0, 0, 0, '0, '0, 0, '0, 2'd0);
    check("reset.fill_block", o_fblock, '0);
    check("reset.miss_count", o_mc, 0);
    check("reset.wb_count", o_wc, 0);
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    do_miss(0, 64'h1238, 1, 0, 0, 64'h5550, rnd128(), rnd128());
    hits(0, 2);
    do_miss(0, 64'h40, 0, 1, 1, 64'h9000, rnd128(), rnd128());
    hits(0, 20);
    do_miss(0, 64'h100, 1, 0, 0, 64'h0, rnd128(), rnd128());
    do_miss(0, 64'h200, 1, 0, 1, 64'h7700, rnd128(), rnd128());
    hits(0, 2);

    // Reset on the second RD cycle with the request still presented.
    sel = 0;
    cpu_read = 1'b1; cpu_write = 1'b0; cpu_addr = 64'h3338; victim_dirty = 1'b0;
    victim_addr = 64'h0; victim_block = '0; mem_rdata = rnd128();
    set_miss(0, 1'b1);
    expect_cycle("abort_idle", 1, 0, 0, '0, '0, 0, '0, 2'd0);
    next_cycle();
    expect_cycle("abort_rd1", 1, 1, 0, 64'h3330, '0, 0, '0, 2'd2);
    next_cycle();
    rst_n = 1'b0;
    mc = '{0, 0}; wc = '{0, 0};
    for (int i = 0; i < 3; i++) begin
      expect_cycle("in_reset", 1, 0, 0, '0, '0, 0, '0, 2'd0);
      check("in_reset.fill_block", o_fblock, '0);
      check("in_reset.miss_count", o_mc, 0);
      check("in_reset.wb_count", o_wc, 0);
      next_cycle();
    end
    rst_n = 1'b1;
    do_miss(0, 64'h3338, 1, 0, 0, 64'h0, rnd128(), rnd128());
    hits(0, 3);

    for (int i = 0; i < 40; i++) begin
      rand_miss(0, 1'b0);
      hits(0, $urandom_range(0, 3));
    end

    for (int i = 0; i < 5; i++) begin
      rand_miss(1, 1'b1);
      hits(1, $urandom_range(0, 2));
    end
    for (int i = 0; i < 4; i++) begin
      rand_miss(1, 1'b0);
      hits(1, $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
